// File: rtl/home_action_arbiter.sv
// home_action_arbiter: latches eat/sleep requests and sequences them onto the shared home-action
// datapath with urgency/round-robin selection, cooldown and a watchdog.
// Define HOME_AUTO_CARE_EN to let stats at or above AUTO_LEVEL raise requests on their own.
module home_action_arbiter #(
    parameter int unsigned STAT_W          = 8,
    parameter int unsigned URGENT_LEVEL    = 200,
    parameter int unsigned AUTO_LEVEL      = 230,
    parameter int unsigned COOLDOWN_CYCLES = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_eat,
    input  logic              req_sleep,
    input  logic [STAT_W-1:0] hunger,
    input  logic [STAT_W-1:0] sleepiness,
    input  logic              action_done,
    output logic              do_eat,
    output logic              do_sleep,
    output logic              busy,
    output logic [1:0]        active,
    output logic              pend_eat,
    output logic              pend_sleep,
    output logic              timeout_err
);

`ifdef HOME_AUTO_CARE_EN
    localparam bit AUTO_CARE_EN = 1'b1;
`else
    localparam bit AUTO_CARE_EN = 1'b0;
`endif

    localparam int unsigned CNT_MAX = (COOLDOWN_CYCLES > TIMEOUT_CYCLES) ? COOLDOWN_CYCLES
                                                                         : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

    // Terminal counts; only used when the matching parameter is non-zero.
    localparam logic [CNT_W-1:0]  TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CD_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [STAT_W-1:0] URGENT_LVL = STAT_W'(URGENT_LEVEL);
    localparam logic [STAT_W-1:0] AUTO_LVL   = STAT_W'(AUTO_LEVEL);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StRelease,
        StCooldown
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_sleep_q;

    logic eat_urgent;
    logic sleep_urgent;
    logic auto_eat;
    logic auto_sleep;
    logic set_eat;
    logic set_sleep;
    logic grant_now;
    logic pick_sleep;

    always_comb begin
        eat_urgent   = hunger >= URGENT_LVL;
        sleep_urgent = sleepiness >= URGENT_LVL;
        auto_eat     = AUTO_CARE_EN && (state_q == StIdle) && !pend_eat && !pend_sleep &&
                       (hunger >= AUTO_LVL);
        auto_sleep   = AUTO_CARE_EN && (state_q == StIdle) && !pend_eat && !pend_sleep &&
                       (sleepiness >= AUTO_LVL);
        set_eat      = req_eat | auto_eat;
        set_sleep    = req_sleep | auto_sleep;
        grant_now    = (state_q == StIdle) && (pend_eat || pend_sleep);

        // A lone urgent stat overrides fairness; otherwise serve the one not served last.
        if (!pend_eat) begin
            pick_sleep = 1'b1;
        end else if (!pend_sleep) begin
            pick_sleep = 1'b0;
        end else if (eat_urgent != sleep_urgent) begin
            pick_sleep = sleep_urgent;
        end else begin
            pick_sleep = !last_sleep_q;
        end
    end

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            last_sleep_q <= 1'b1;
            do_eat       <= 1'b0;
            do_sleep     <= 1'b0;
            active       <= 2'b00;
            pend_eat     <= 1'b0;
            pend_sleep   <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            // Set wins over the grant clear so a re-request during the grant is kept.
            pend_eat    <= set_eat | (pend_eat & ~(grant_now & ~pick_sleep));
            pend_sleep  <= set_sleep | (pend_sleep & ~(grant_now & pick_sleep));

            unique case (state_q)
                StIdle: begin
                    if (grant_now) begin
                        state_q      <= StGrant;
                        cnt_q        <= '0;
                        do_eat       <= !pick_sleep;
                        do_sleep     <= pick_sleep;
                        active       <= pick_sleep ? 2'b10 : 2'b01;
                        last_sleep_q <= pick_sleep;
                    end
                end
                StGrant: begin
                    if (action_done) begin
                        state_q  <= StRelease;
                        cnt_q    <= '0;
                        do_eat   <= 1'b0;
                        do_sleep <= 1'b0;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                        state_q     <= StRelease;
                        cnt_q       <= '0;
                        do_eat      <= 1'b0;
                        do_sleep    <= 1'b0;
                        timeout_err <= 1'b1;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StRelease: begin
                    if (!action_done) begin
                        state_q <= (COOLDOWN_CYCLES == 0) ? StIdle : StCooldown;
                        cnt_q   <= '0;
                        active  <= 2'b00;
                    end
                end
                StCooldown: begin
                    if (cnt_q == CD_LAST) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_home_action_arbiter.sv
// Scoreboard bench for home_action_arbiter: the driver predicts each grant from the selection
// rules and queues it; a monitor checks every grant and release the DUT presents.
module tb_home_action_arbiter;

    localparam int TMO  = 20;
    localparam int COOL = 4;

    logic       clk         = 1'b0;
    logic       resetn      = 1'b0;
    logic       req_eat     = 1'b0;
    logic       req_sleep   = 1'b0;
    logic       action_done = 1'b0;
    logic [7:0] hunger      = 8'd0;
    logic [7:0] sleepiness  = 8'd0;
    logic       do_eat;
    logic       do_sleep;
    logic       busy;
    logic [1:0] active;
    logic       pend_eat;
    logic       pend_sleep;
    logic       timeout_err;

    home_action_arbiter #(
        .STAT_W         (8),
        .URGENT_LEVEL   (200),
        .AUTO_LEVEL     (230),
        .COOLDOWN_CYCLES(COOL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_eat    (req_eat),
        .req_sleep  (req_sleep),
        .hunger     (hunger),
        .sleepiness (sleepiness),
        .action_done(action_done),
        .do_eat     (do_eat),
        .do_sleep   (do_sleep),
        .busy       (busy),
        .active     (active),
        .pend_eat   (pend_eat),
        .pend_sleep (pend_sleep),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic is_sleep;
        logic timeout;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    bit   last_sleep = 1'b1;  // model: which action was served last

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Reference selection rule, from the pending set and stats alone.
    function automatic bit model_pick_sleep(input bit pe, input bit ps, input int h, input int s);
        bit eu = (h >= 200);
        bit su = (s >= 200);
        if (!pe) return 1'b1;
        if (!ps) return 1'b0;
        if (eu != su) return su;
        return !last_sleep;
    endfunction

    task automatic push_exp(input bit is_sleep, input int dly);
        exp_t e;
        e.is_sleep = is_sleep;
        e.timeout  = (dly >= TMO);
        exp_q.push_back(e);
        last_sleep = is_sleep;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || pend_eat || pend_sleep) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) fail_now("wait_idle");
    endtask

    task automatic wait_grant();
        int n = 0;
        while (!(do_eat || do_sleep) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail_now("wait_grant");
    endtask

    // Acts as the datapath: answer after dly cycles, or never if dly reaches the watchdog.
    task automatic serve(input int dly);
        int n = 0;
        wait_grant();
        if (dly >= TMO) begin
            while ((do_eat || do_sleep) && n < 60) begin
                @(negedge clk);
                n++;
            end
            check("grant_cycles", n, TMO);
            return;
        end
        repeat (dly) @(negedge clk);
        action_done = 1'b1;
        while ((do_eat || do_sleep) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) fail_now("wait_release");
        @(negedge clk);
        action_done = 1'b0;
    endtask

    task automatic run_round(input bit re, input bit rs, input int h, input int s,
                             input int d0, input int d1);
        bit first;
        wait_idle();
        @(negedge clk);
        hunger     = 8'(h);
        sleepiness = 8'(s);
        req_eat    = re;
        req_sleep  = rs;
        first = model_pick_sleep(re, rs, h, s);
        push_exp(first, d0);
        if (re && rs) push_exp(!first, d1);
        @(negedge clk);
        req_eat   = 1'b0;
        req_sleep = 1'b0;
        serve(d0);
        if (re && rs) serve(d1);
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn     = 1'b1;
        last_sleep = 1'b1;
    endtask

    // Monitor: pops on each grant, checks the abort flag on each release.
    initial begin
        bit   prev_do = 1'b0;
        bit   cur_do;
        exp_t cur = '0;
        forever begin
            @(negedge clk);
            cur_do = do_eat || do_sleep;
            if (cur_do && !prev_do) begin
                if (exp_q.size() == 0) begin
                    fail_now("grant_unexpected");
                end else begin
                    cur = exp_q.pop_front();
                    check("grant_action", {31'd0, do_sleep}, {31'd0, cur.is_sleep});
                end
            end
            if (!cur_do && prev_do) check("timeout_flag", timeout_err, cur.timeout);
            else check("timeout_quiet", timeout_err, 0);
            if (do_eat && do_sleep) fail_now("do_mutex");
            prev_do = cur_do;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int re;
        int rs;
        repeat (3) @(negedge clk);
        check("rst_do_eat", do_eat, 0);
        check("rst_do_sleep", do_sleep, 0);
        check("rst_busy", busy, 0);
        check("rst_active", active, 0);
        check("rst_pend_eat", pend_eat, 0);
        check("rst_pend_sleep", pend_sleep, 0);
        check("rst_timeout", timeout_err, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Single eat with cycle-exact timing.
        hunger     = 8'd50;
        sleepiness = 8'd50;
        req_eat    = 1'b1;
        push_exp(1'b0, 0);
        @(negedge clk);
        req_eat = 1'b0;
        check("lat_pend", pend_eat, 1);
        check("lat_do_early", do_eat, 0);
        @(negedge clk);
        check("lat_do", do_eat, 1);
        check("lat_active", active, 2'b01);
        check("lat_pend_clr", pend_eat, 0);
        check("lat_busy", busy, 1);
        repeat (3) @(negedge clk);
        action_done = 1'b1;
        @(negedge clk);
        check("rel_do", do_eat, 0);
        check("rel_active", active, 2'b01);
        action_done = 1'b0;
        @(negedge clk);
        check("cool_active", active, 0);
        check("cool_busy0", busy, 1);
        repeat (COOL - 1) @(negedge clk);
        check("cool_busy3", busy, 1);
        @(negedge clk);
        check("cool_idle", busy, 0);

        // Ties alternate, then urgency overrides the pointer.
        do_reset();
        run_round(1'b1, 1'b1, 50, 50, 2, 3);
        run_round(1'b1, 1'b1, 50, 50, 1, 0);
        run_round(1'b1, 1'b1, 100, 210, 1, 4);

        // Watchdog abort.
        run_round(1'b1, 1'b0, 50, 50, 25, 0);
        check("wd_pend_eat", pend_eat, 0);

        // Re-request during grant re-runs eat after cooldown.
        wait_idle();
        @(negedge clk);
        req_eat = 1'b1;
        push_exp(1'b0, 2);
        push_exp(1'b0, 2);
        @(negedge clk);
        req_eat = 1'b0;
        wait_grant();
        req_eat = 1'b1;
        @(negedge clk);
        req_eat = 1'b0;
        check("rereq_pend", pend_eat, 1);
        serve(2);
        serve(2);
        wait_idle();

        // Reset mid-grant drops the action and pending requests.
        @(negedge clk);
        req_eat = 1'b1;
        push_exp(1'b0, 0);
        @(negedge clk);
        req_eat = 1'b0;
        wait_grant();
        req_sleep = 1'b1;
        @(negedge clk);
        req_sleep = 1'b0;
        check("mid_pend_sleep", pend_sleep, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_do", do_eat, 0);
        check("mid_rst_pe", pend_eat, 0);
        check("mid_rst_ps", pend_sleep, 0);
        check("mid_rst_active", active, 0);
        resetn     = 1'b1;
        last_sleep = 1'b1;
        @(negedge clk);

        // Auto-care from a neglected stat.
        wait_idle();
        @(negedge clk);
        hunger     = 8'd230;
        sleepiness = 8'd0;
`ifdef HOME_AUTO_CARE_EN
        push_exp(1'b0, 2);
        @(negedge clk);
        check("auto_pend", pend_eat, 1);
        check("auto_do_early", do_eat, 0);
        @(negedge clk);
        check("auto_do", do_eat, 1);
        hunger = 8'd0;
        serve(2);
        wait_idle();
`else
        repeat (10) @(negedge clk);
        check("noauto_do", do_eat, 0);
        check("noauto_pend", pend_eat, 0);
        check("noauto_busy", busy, 0);
        hunger = 8'd0;
`endif

        // Randomized rounds around the urgency threshold.
        for (int i = 0; i < 30; i++) begin
            re = int'($urandom_range(0, 1));
            rs = int'($urandom_range(0, 1));
            if (re == 0 && rs == 0) re = 1;
            run_round(re[0], rs[0], int'($urandom_range(150, 229)),
                      int'($urandom_range(150, 229)), int'($urandom_range(0, 24)),
                      int'($urandom_range(0, 24)));
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
